cpu_amo_bank_sched: RTL
=======================

// Module: cpu_amo_bank_sched
// PURPOSE
//  Per-L2-bank scheduler for CPU AMO-store requests. Shares one L2 bank AMO port between CPU_PORT_CNT
//  requesters using a round-robin arbiter with grant lock, a per-CPU outstanding-credit limit and a
//  1-entry registered output stage. One instance per bank sits between the per-CPU input buffers and
//  the L2 AMO request port. Responses carrying req_tid.cpu_noc_id return credits.
// PARAMETERS
//  CPU_PORT_CNT  8  number of requesting CPU ports; >=2
//  MAX_OUTST     4  max un-responded AMO stores per CPU at this bank; >=1
//  CNT_W         $clog2(MAX_OUTST+1)  credit counter width (derived; not overridden)
// PORTS
//  clk              in   1                   clock
//  rstn             in   1                   async active-low reset
//  req_valid        in   CPU_PORT_CNT        per-CPU request valid
//  req_ready        out  CPU_PORT_CNT        per-CPU request ready (one-hot or zero)
//  req_info         in   CPU_PORT_CNT x cpu_cache_if_req_t   per-CPU request payload
//  l2_req_valid     out  1                   request to L2 bank valid
//  l2_req_ready     in   1                   L2 bank accepts
//  l2_req           out  cpu_cache_if_req_t  registered payload
//  l2_resp_valid    in   1                   AMO-store completion for this bank
//  l2_resp_cpu_id   in   $clog2(CPU_PORT_CNT) CPU whose credit is returned
//  outst_cnt        out  CPU_PORT_CNT x CNT_W current outstanding count per CPU (debug/perf)
//  credit_err       out  1                   sticky: response returned with count already 0
// BEHAVIOUR
//  Reset (rstn=0, async): l2_req_valid=0, l2_req=0, all outst_cnt=0, credit_err=0, rr pointer=0,
//   lock=0. req_ready is combinational and therefore 0 while l2_req_valid=0 is not required; it follows
//   the rules below from the reset state.
//  Eligibility: elig[i] = req_valid[i] & (outst_cnt[i] < MAX_OUTST).
//  Arbitration: first eligible index at or after rr pointer (wrapping, CPU_PORT_CNT-1 -> 0).
//  Grant lock: if the chosen requester is not accepted in a cycle, lock=1 and the grant is held on the
//   same index; lock clears on handshake. Inputs follow valid/ready rules (valid stable until ready).
//  Output stage: load = (~l2_req_valid | l2_req_ready) & |elig. req_ready[g]=load, others 0.
//   On load: l2_req <= req_info[g], l2_req_valid <= 1, rr pointer <= g+1 (wrap). Otherwise if
//   l2_req_ready: l2_req_valid <= 0. Latency input-handshake -> l2_req_valid: 1 cycle; full throughput
//   (one request/cycle) when l2_req_ready held high.
//  l2_req is unmodified from req_info (cpu_noc_id already set upstream).
//  Credits: outst_cnt[i] +1 on input handshake of i, -1 on l2_resp_valid with l2_resp_cpu_id==i;
//   both same cycle -> unchanged. Counter never exceeds MAX_OUTST (eligibility gate).
//  Boundary: response for id with count 0 and no same-cycle issue -> count stays 0, credit_err <= 1
//   (sticky until reset). l2_resp_cpu_id >= CPU_PORT_CNT -> ignored, credit_err <= 1.
//  A CPU at MAX_OUTST is skipped; it re-enters arbitration the cycle after a credit return.
//  Held locked grant must not be pre-empted even if its count reaches MAX_OUTST (cannot: count only
//   rises on its own handshake).
// STRUCTURE
//  pygmy_cfg: CPU_PORT_CNT default, AMO_MAX_OUTST constant. pygmy_intf_typedef: cpu_cache_if_req_t.
//  Sub-module: cpu_amo_rr_pick (combinational rotate-priority picker: elig + pointer -> one-hot grant
//   and index). Credit counters, lock and output register live in the top module.
// TESTING
//  1 Reset then CPU3 single req, ready=1 -> l2_req_valid next cycle, payload equal, outst_cnt[3]=1.
//  2 All 8 CPUs valid, ready=1, no responses, MAX_OUTST=4 -> grants 0,1..7,0.. in order; each CPU
//    granted exactly 4 times, then all req_ready=0; 32 outputs.
//  3 CPU1,CPU2 valid, l2_req_ready=0 for 5 cycles -> l2_req holds CPU1 payload, no req_ready;
//    release -> CPU2 loaded same cycle CPU1 leaves, pointer=3.
//  4 CPU5 at count 4; l2_resp_valid with id 5 same cycle as nothing -> count 3, CPU5 granted next.
//  5 Same-cycle issue and response for CPU0 at count 2 -> count stays 2; response to CPU6 at 0 ->
//    credit_err=1 and stays 1.
//  6 Assert rstn low mid-burst with l2_req_valid=1 -> outputs/counters 0 immediately; recover clean.

Source files
------------

// File: rtl/cpu_amo_bank_sched_pkg.sv
// rtl/cpu_amo_bank_sched_pkg.sv - shared configuration and request payload types for the AMO bank scheduler
package cpu_amo_bank_sched_pkg;

  localparam int CFG_CPU_PORT_CNT  = 8;
  localparam int CFG_AMO_MAX_OUTST = 4;
  localparam int CPU_ID_W          = $clog2(CFG_CPU_PORT_CNT);

  typedef enum logic [1:0] {
    AMO_ADD  = 2'd0,
    AMO_SWAP = 2'd1,
    AMO_AND  = 2'd2,
    AMO_OR   = 2'd3
  } amo_op_e;

  typedef struct packed {
    logic [CPU_ID_W-1:0] cpu_noc_id;
    logic [3:0]          tid;
  } req_tid_t;

  typedef struct packed {
    amo_op_e     op;
    logic [31:0] addr;
    logic [31:0] data;
    req_tid_t    req_tid;
  } cpu_cache_if_req_t;

endpackage

// File: rtl/cpu_amo_bank_sched_if.sv
// rtl/cpu_amo_bank_sched_if.sv - CPU request, L2 request and L2 response signals of one bank scheduler
interface cpu_amo_bank_sched_if
  import cpu_amo_bank_sched_pkg::*;
#(
  parameter int CPU_PORT_CNT = CFG_CPU_PORT_CNT
) ();

  localparam int ID_W = $clog2(CPU_PORT_CNT);

  logic [CPU_PORT_CNT-1:0]              req_valid;
  logic [CPU_PORT_CNT-1:0]              req_ready;
  cpu_cache_if_req_t [CPU_PORT_CNT-1:0] req_info;
  logic                                 l2_req_valid;
  logic                                 l2_req_ready;
  cpu_cache_if_req_t                    l2_req;
  logic                                 l2_resp_valid;
  logic [ID_W-1:0]                      l2_resp_cpu_id;

  modport master (
    output req_valid, req_info, l2_req_ready, l2_resp_valid, l2_resp_cpu_id,
    input  req_ready, l2_req_valid, l2_req
  );

  modport slave (
    input  req_valid, req_info, l2_req_ready, l2_resp_valid, l2_resp_cpu_id,
    output req_ready, l2_req_valid, l2_req
  );

endinterface

// File: rtl/cpu_amo_rr_pick.sv
// rtl/cpu_amo_rr_pick.sv - rotate-priority picker: first eligible index at or after the pointer
module cpu_amo_rr_pick #(
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  int idx;

  // Walk the requesters starting at ptr, wrapping, and take the first eligible one
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_any && elig[idx]) begin
        grant_any     = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/cpu_amo_bank_sched.sv
// rtl/cpu_amo_bank_sched.sv - per-bank AMO-store scheduler: round-robin with grant lock, credits, output register
module cpu_amo_bank_sched
  import cpu_amo_bank_sched_pkg::*;
#(
  parameter  int CPU_PORT_CNT = CFG_CPU_PORT_CNT,
  parameter  int MAX_OUTST    = CFG_AMO_MAX_OUTST,
  localparam int CNT_W        = $clog2(MAX_OUTST + 1),
  localparam int IDX_W        = $clog2(CPU_PORT_CNT)
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  cpu_amo_bank_sched_if.slave                  bus,
  output logic [CPU_PORT_CNT-1:0][CNT_W-1:0]   outst_cnt,
  output logic                                 credit_err
);

  logic [CPU_PORT_CNT-1:0] elig;
  logic [CPU_PORT_CNT-1:0] pick_oh;
  logic [CPU_PORT_CNT-1:0] sel_oh;
  logic [CPU_PORT_CNT-1:0] inc;
  logic [CPU_PORT_CNT-1:0] dec;
  logic [CPU_PORT_CNT-1:0] uflow;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W-1:0]        lock_idx;
  logic [IDX_W-1:0]        sel_idx;
  logic                    pick_any;
  logic                    lock;
  logic                    sel_valid;
  logic                    load;
  logic                    resp_in_range;

  // A CPU competes only while it has a request and a free credit at this bank
  always_comb begin
    elig = '0;
    for (int i = 0; i < CPU_PORT_CNT; i++) begin
      elig[i] = bus.req_valid[i] & (outst_cnt[i] < CNT_W'(MAX_OUTST));
    end
  end

  cpu_amo_rr_pick #(
    .N (CPU_PORT_CNT)
  ) u_pick (
    .elig      (elig),
    .ptr       (rr_pointer_q()),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .grant_any (pick_any)
  );

  function automatic logic [IDX_W-1:0] rr_pointer_q();
    return rr_ptr;
  endfunction

  // A stalled grant stays on its index until it handshakes, even if the picker would now choose another
  always_comb begin
    sel_idx   = pick_idx;
    sel_oh    = pick_oh;
    sel_valid = pick_any;
    if (lock && elig[lock_idx]) begin
      sel_idx   = lock_idx;
      sel_oh    = CPU_PORT_CNT'(1) << lock_idx;
      sel_valid = 1'b1;
    end
  end

  assign load          = (~bus.l2_req_valid | bus.l2_req_ready) & sel_valid;
  assign bus.req_ready = load ? sel_oh : '0;
  assign resp_in_range = ({1'b0, bus.l2_resp_cpu_id} < (IDX_W + 1)'(CPU_PORT_CNT));

  // Per-CPU credit events: issue on input handshake, return on an in-range response
  always_comb begin
    inc   = '0;
    dec   = '0;
    uflow = '0;
    for (int i = 0; i < CPU_PORT_CNT; i++) begin
      inc[i]   = bus.req_valid[i] & bus.req_ready[i];
      dec[i]   = bus.l2_resp_valid & resp_in_range & (bus.l2_resp_cpu_id == IDX_W'(i));
      uflow[i] = dec[i] & ~inc[i] & (outst_cnt[i] == '0);
    end
  end

  // Output register, rotate pointer and grant lock
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.l2_req_valid <= 1'b0;
      bus.l2_req       <= '0;
      rr_ptr           <= '0;
      lock             <= 1'b0;
      lock_idx         <= '0;
    end else begin
      if (load) begin
        bus.l2_req       <= bus.req_info[sel_idx];
        bus.l2_req_valid <= 1'b1;
        rr_ptr           <= (sel_idx == IDX_W'(CPU_PORT_CNT - 1)) ? '0 : sel_idx + IDX_W'(1);
      end else if (bus.l2_req_ready) begin
        bus.l2_req_valid <= 1'b0;
      end
      lock <= sel_valid & ~load;
      if (sel_valid && !load) lock_idx <= sel_idx;
    end
  end

  // Outstanding counters; a simultaneous issue and return cancel out, and zero never wraps
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outst_cnt <= '0;
    end else begin
      for (int i = 0; i < CPU_PORT_CNT; i++) begin
        if (inc[i] && !dec[i]) begin
          outst_cnt[i] <= outst_cnt[i] + CNT_W'(1);
        end else if (dec[i] && !inc[i] && outst_cnt[i] != '0) begin
          outst_cnt[i] <= outst_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // Sticky flag for responses that return a credit nobody holds or name a non-existent CPU
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credit_err <= 1'b0;
    end else if (bus.l2_resp_valid && (!resp_in_range || (|uflow))) begin
      credit_err <= 1'b1;
    end
  end

endmodule
